// File: rtl/pipe_alu_wb.sv
// pipe_alu_wb: parametrised 4-stage register-read / ALU / writeback / store pipeline.
//
// Ports:
//   clk, rst_n              single rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready      instruction issue handshake (accept on in_valid && in_ready)
//   rs1, rs2, rd            source / destination register indexes
//   func                    ALU opcode (16 fully defined operations)
//   wb_en, st_en, addr      write result to regbank[rd] / store result to mem[addr]
//   rf_we, rf_waddr, rf_wdata  register preload port (pipeline writeback has priority)
//   mem_raddr, mem_rdata    registered, read-before-write memory readback
//   zout, zout_valid        stage-3 result and its valid flag
//
// Stage timing for an instruction accepted on edge t:
//   t   : operands latched into S1 (with forwarding from S2)
//   t+1 : ALU result latched into S2
//   t+2 : result moves to S3 (zout) and is written to regbank[rd]
//   t+3 : result stored to mem[addr]
module pipe_alu_wb #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [3:0]        func,
    input  logic              wb_en,
    input  logic              st_en,
    input  logic [MEM_AW-1:0] addr,
    input  logic              rf_we,
    input  logic [REG_AW-1:0] rf_waddr,
    input  logic [DATA_W-1:0] rf_wdata,
    input  logic [MEM_AW-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] zout,
    output logic              zout_valid
);

    localparam int NREG = 2 ** REG_AW;
    localparam int NMEM = 2 ** MEM_AW;

    // ALU: every opcode yields a defined DATA_W-bit value.
    function automatic logic [DATA_W-1:0] alu_f(
        input logic [3:0]        f,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W-1:0]   r;
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        case (f)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = prod[DATA_W-1:0];
            4'd3:    r = a;
            4'd4:    r = b;
            4'd5:    r = a & b;
            4'd6:    r = a | b;
            4'd7:    r = a ^ b;
            4'd8:    r = {DATA_W{1'b0}} - a;
            4'd9:    r = {DATA_W{1'b0}} - b;
            4'd10:   r = {1'b0, a[DATA_W-1:1]};
            4'd11:   r = {a[DATA_W-2:0], 1'b0};
            4'd12:   r = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : {DATA_W{1'b0}};
            4'd13:   r = {a[DATA_W-1], a[DATA_W-1:1]};
            4'd14:   r = ~a;
            4'd15:   r = {DATA_W{1'b0}};
            default: r = {DATA_W{1'b0}};
        endcase
        return r;
    endfunction

    // Architectural state (not reset)
    logic [DATA_W-1:0] regbank_r [NREG];
    logic [DATA_W-1:0] mem_r     [NMEM];

    // S1: operands and control
    logic              s1_valid_r;
    logic [DATA_W-1:0] s1_a_r;
    logic [DATA_W-1:0] s1_b_r;
    logic [REG_AW-1:0] s1_rd_r;
    logic [3:0]        s1_func_r;
    logic              s1_wb_r;
    logic              s1_st_r;
    logic [MEM_AW-1:0] s1_addr_r;

    // S2: ALU result
    logic              s2_valid_r;
    logic [DATA_W-1:0] s2_z_r;
    logic [REG_AW-1:0] s2_rd_r;
    logic              s2_wb_r;
    logic              s2_st_r;
    logic [MEM_AW-1:0] s2_addr_r;

    // S3: visible result, pending store
    logic              s3_valid_r;
    logic [DATA_W-1:0] s3_z_r;
    logic              s3_st_r;
    logic [MEM_AW-1:0] s3_addr_r;

    logic [DATA_W-1:0] mem_rdata_r;

    logic              stall_s;
    logic              accept_s;
    logic              fwd_a_s;
    logic              fwd_b_s;
    logic [DATA_W-1:0] opa_s;
    logic [DATA_W-1:0] opb_s;
    logic              wb_fire_s;
    logic              st_fire_s;

    // Hazard detection: an S1 producer's result does not exist yet, so the consumer must wait a cycle.
    always_comb begin
        stall_s = 1'b0;
        if (s1_valid_r && s1_wb_r && ((rs1 == s1_rd_r) || (rs2 == s1_rd_r))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign in_ready  = rst_n & ~stall_s;
    assign accept_s  = in_valid & in_ready;
    assign wb_fire_s = s2_valid_r & s2_wb_r;
    assign st_fire_s = s3_valid_r & s3_st_r;

    // Operand select: an S2 producer is writing regbank on this very edge, so take its Z directly.
    always_comb begin
        fwd_a_s = wb_fire_s && (rs1 == s2_rd_r);
        fwd_b_s = wb_fire_s && (rs2 == s2_rd_r);
        if (fwd_a_s) begin
            opa_s = s2_z_r;
        end else begin
            opa_s = regbank_r[rs1];
        end
        if (fwd_b_s) begin
            opb_s = s2_z_r;
        end else begin
            opb_s = regbank_r[rs2];
        end
    end

    // S1 register: operand/control capture; a bubble enters whenever nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {DATA_W{1'b0}};
            s1_b_r     <= {DATA_W{1'b0}};
            s1_rd_r    <= {REG_AW{1'b0}};
            s1_func_r  <= 4'd0;
            s1_wb_r    <= 1'b0;
            s1_st_r    <= 1'b0;
            s1_addr_r  <= {MEM_AW{1'b0}};
        end else begin
            s1_valid_r <= accept_s;
            s1_a_r     <= opa_s;
            s1_b_r     <= opb_s;
            s1_rd_r    <= rd;
            s1_func_r  <= func;
            s1_wb_r    <= wb_en;
            s1_st_r    <= st_en;
            s1_addr_r  <= addr;
        end
    end

    // S2 register: ALU evaluation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_z_r     <= {DATA_W{1'b0}};
            s2_rd_r    <= {REG_AW{1'b0}};
            s2_wb_r    <= 1'b0;
            s2_st_r    <= 1'b0;
            s2_addr_r  <= {MEM_AW{1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_z_r     <= alu_f(s1_func_r, s1_a_r, s1_b_r);
            s2_rd_r    <= s1_rd_r;
            s2_wb_r    <= s1_wb_r;
            s2_st_r    <= s1_st_r;
            s2_addr_r  <= s1_addr_r;
        end
    end

    // S3 register: visible result plus the store that lands one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_r <= 1'b0;
            s3_z_r     <= {DATA_W{1'b0}};
            s3_st_r    <= 1'b0;
            s3_addr_r  <= {MEM_AW{1'b0}};
        end else begin
            s3_valid_r <= s2_valid_r;
            s3_z_r     <= s2_z_r;
            s3_st_r    <= s2_st_r;
            s3_addr_r  <= s2_addr_r;
        end
    end

    // Register file write: preload first, writeback second so writeback wins on an address clash.
    always_ff @(posedge clk) begin
        if (rf_we) begin
            regbank_r[rf_waddr] <= rf_wdata;
        end
        if (wb_fire_s) begin
            regbank_r[s2_rd_r] <= s2_z_r;
        end
    end

    // Data memory store; gated by the S3 valid bit so reset cancels in-flight stores.
    always_ff @(posedge clk) begin
        if (st_fire_s) begin
            mem_r[s3_addr_r] <= s3_z_r;
        end
    end

    // Readback register: samples the pre-edge memory contents (read-before-write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_rdata_r <= mem_r[mem_raddr];
        end
    end

    assign mem_rdata  = mem_rdata_r;
    assign zout       = s3_z_r;
    assign zout_valid = s3_valid_r;

endmodule

// File: tb/tb_pipe_alu_wb.sv
// Self-checking bench for pipe_alu_wb. The reference model executes accepted
// instructions sequentially against an architectural register/memory image and
// predicts zout two edges after acceptance; in_ready is predicted from the rule
// "the instruction accepted on the previous edge writes a register this one reads".
module tb_pipe_alu_wb;

    localparam int DW  = 16;
    localparam int RAW = 4;
    localparam int MAW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [RAW-1:0] rs1, rs2, rd;
    logic [3:0]     func;
    logic           wb_en, st_en;
    logic [MAW-1:0] addr;
    logic           rf_we;
    logic [RAW-1:0] rf_waddr;
    logic [DW-1:0]  rf_wdata;
    logic [MAW-1:0] mem_raddr;
    logic [DW-1:0]  mem_rdata;
    logic [DW-1:0]  zout;
    logic           zout_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0]  m_rf  [16];
    logic [DW-1:0]  m_mem [256];
    bit             m_wr  [256];
    logic           h_valid [1:3];
    logic [DW-1:0]  h_z     [1:3];
    logic           last_acc;
    logic           last_wb;
    logic [RAW-1:0] last_rd;

    always #5 clk = ~clk;

    pipe_alu_wb #(.DATA_W(DW), .REG_AW(RAW), .MEM_AW(MAW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .wb_en(wb_en), .st_en(st_en),
        .addr(addr), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .zout(zout), .zout_valid(zout_valid)
    );

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (f)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a * b;
            4'd3:    r = a;
            4'd4:    r = b;
            4'd5:    r = a & b;
            4'd6:    r = a | b;
            4'd7:    r = a ^ b;
            4'd8:    r = -a;
            4'd9:    r = -b;
            4'd10:   r = a >> 1;
            4'd11:   r = a << 1;
            4'd12:   r = (a < b) ? 16'd1 : 16'd0;
            4'd13:   r = $signed(a) >>> 1;
            4'd14:   r = ~a;
            default: r = 16'd0;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [RAW-1:0] s1, input logic [RAW-1:0] s2, input logic [RAW-1:0] d,
                         input logic [3:0] f, input logic w, input logic s, input logic [MAW-1:0] a);
        in_valid = 1'b1; rs1 = s1; rs2 = s2; rd = d; func = f; wb_en = w; st_en = s; addr = a;
    endtask

    task automatic idle();
        in_valid = 1'b0; wb_en = 1'b0; st_en = 1'b0; rf_we = 1'b0;
    endtask

    task automatic clear_model_pipe();
        for (int i = 1; i <= 3; i++) begin
            h_valid[i] = 1'b0;
            h_z[i]     = 16'd0;
        end
        last_acc = 1'b0; last_wb = 1'b0; last_rd = 4'd0;
    endtask

    // One clock cycle: predict handshake and zout, advance the model, then pass the edge.
    task automatic tick();
        logic          exp_ready;
        logic          acc;
        logic [DW-1:0] z;
        @(negedge clk);
        exp_ready = !(last_acc && last_wb && ((rs1 == last_rd) || (rs2 == last_rd)));
        checks++;
        if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, exp_ready);
        end
        checks++;
        if ((zout_valid !== h_valid[3]) || (h_valid[3] && (zout !== h_z[3]))) begin
            errors++;
            $display("FAIL zout @%0t: got v=%b z=%h expected v=%b z=%h", $time, zout_valid, zout, h_valid[3], h_z[3]);
        end
        acc = in_valid && exp_ready;
        z = 16'd0;
        if (acc) begin
            z = ref_alu(func, m_rf[rs1], m_rf[rs2]);
            if (wb_en) m_rf[rd] = z;
            if (st_en) begin
                m_mem[addr] = z;
                m_wr[addr]  = 1'b1;
            end
        end
        if (rf_we) m_rf[rf_waddr] = rf_wdata;
        h_valid[3] = h_valid[2]; h_z[3] = h_z[2];
        h_valid[2] = h_valid[1]; h_z[2] = h_z[1];
        h_valid[1] = acc;        h_z[1] = z;
        last_acc = acc; last_wb = wb_en; last_rd = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [RAW-1:0] a, input logic [DW-1:0] d);
        idle();
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        tick();
        rf_we = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; rs1 = 4'd0; rs2 = 4'd0; rd = 4'd0; func = 4'd0;
        wb_en = 1'b0; st_en = 1'b0; addr = 8'd0; rf_we = 1'b0; rf_waddr = 4'd0;
        rf_wdata = 16'd0; mem_raddr = 8'd0;
        for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;
        clear_model_pipe();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (zout_valid !== 1'b0 || zout !== 16'd0 || mem_rdata !== 16'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got zv=%b z=%h rd=%h rdy=%b expected 0/0000/0000/0",
                     zout_valid, zout, mem_rdata, in_ready);
        end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_basic();
        preload(4'd1, 16'h0005);
        preload(4'd2, 16'h0003);
        drive(4'd1, 4'd2, 4'd3, 4'd0, 1'b1, 1'b0, 8'd0);
        tick();
        idle();
        tick(); tick();
        checks++;
        if (zout_valid !== 1'b1 || zout !== 16'h0008) begin
            errors++;
            $display("FAIL basic_add: got v=%b z=%h expected v=1 z=0008", zout_valid, zout);
        end
        drive(4'd3, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 8'd0);
        tick();
        idle();
        tick(); tick();
        checks++;
        if (zout_valid !== 1'b1 || zout !== 16'h0008) begin
            errors++;
            $display("FAIL basic_readreg: got v=%b z=%h expected v=1 z=0008", zout_valid, zout);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        drive(4'd1, 4'd2, 4'd4, 4'd0, 1'b1, 1'b0, 8'd0);
        tick();
        drive(4'd4, 4'd2, 4'd5, 4'd1, 1'b1, 1'b0, 8'd0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: got in_ready=%b expected 0", in_ready);
        end
        tick();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_release: got in_ready=%b expected 1", in_ready);
        end
        tick();
        idle();
        checks++;
        if (zout_valid !== 1'b1 || zout !== 16'h0008) begin
            errors++;
            $display("FAIL b2b_first: got v=%b z=%h expected v=1 z=0008", zout_valid, zout);
        end
        tick();
        checks++;
        if (zout_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble: got v=%b expected v=0", zout_valid);
        end
        tick();
        checks++;
        if (zout_valid !== 1'b1 || zout !== 16'h0005) begin
            errors++;
            $display("FAIL b2b_second: got v=%b z=%h expected v=1 z=0005", zout_valid, zout);
        end
        drive(4'd5, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 8'd0);
        tick();
        idle();
        tick(); tick();
        checks++;
        if (zout !== 16'h0005) begin
            errors++;
            $display("FAIL b2b_r5: got %h expected 0005", zout);
        end
        drain();
    endtask

    task automatic test_forward();
        preload(4'd4, 16'h0000);
        drive(4'd1, 4'd2, 4'd4, 4'd0, 1'b1, 1'b0, 8'd0);
        tick();
        idle();
        tick();
        drive(4'd4, 4'd2, 4'd6, 4'd2, 1'b0, 1'b0, 8'd0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fwd_nostall: got in_ready=%b expected 1", in_ready);
        end
        tick();
        idle();
        tick(); tick();
        checks++;
        if (zout_valid !== 1'b1 || zout !== 16'h0018) begin
            errors++;
            $display("FAIL fwd_mul: got v=%b z=%h expected v=1 z=0018", zout_valid, zout);
        end
        drain();
    endtask

    task automatic test_store();
        drive(4'd1, 4'd2, 4'd0, 4'd15, 1'b0, 1'b1, 8'h20);
        tick();
        drain();
        drive(4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1, 8'h20);
        tick();
        idle();
        mem_raddr = 8'h20;
        tick(); tick(); tick();
        checks++;
        if (mem_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL store_same_edge: got %h expected 0000", mem_rdata);
        end
        tick();
        checks++;
        if (mem_rdata !== 16'h0008) begin
            errors++;
            $display("FAIL store_readback: got %h expected 0008", mem_rdata);
        end
        drain();
    endtask

    task automatic test_opcodes();
        logic [3:0]    ops  [6];
        logic [DW-1:0] exps [6];
        ops  = '{4'd10, 4'd13, 4'd11, 4'd12, 4'd14, 4'd15};
        exps = '{16'h4000, 16'hC000, 16'h0002, 16'h0000, 16'h7FFE, 16'h0000};
        preload(4'd6, 16'h8001);
        preload(4'd7, 16'h0002);
        for (int i = 0; i < 6; i++) begin
            drive(4'd6, 4'd7, 4'd0, ops[i], 1'b0, 1'b0, 8'd0);
            tick();
            idle();
            tick(); tick();
            checks++;
            if (zout_valid !== 1'b1 || zout !== exps[i]) begin
                errors++;
                $display("FAIL opcode_%0d: got v=%b z=%h expected v=1 z=%h", ops[i], zout_valid, zout, exps[i]);
            end
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        logic [DW-1:0] saved_r3;
        logic [DW-1:0] saved_m20;
        saved_r3  = m_rf[3];
        saved_m20 = m_mem[8'h20];
        drive(4'd1, 4'd2, 4'd3, 4'd1, 1'b1, 1'b1, 8'h20);
        tick();
        idle();
        tick();
        rst_n = 1'b0;
        m_rf[3]      = saved_r3;
        m_mem[8'h20] = saved_m20;
        #1;
        checks++;
        if (zout_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got zv=%b rdy=%b expected 0/0", zout_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model_pipe();
        drive(4'd3, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 8'd0);
        tick();
        idle();
        tick(); tick();
        checks++;
        if (zout !== saved_r3) begin
            errors++;
            $display("FAIL midreset_reg: got %h expected %h", zout, saved_r3);
        end
        mem_raddr = 8'h20;
        tick();
        checks++;
        if (mem_rdata !== saved_m20) begin
            errors++;
            $display("FAIL midreset_mem: got %h expected %h", mem_rdata, saved_m20);
        end
        drain();
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) preload(RAW'(r), 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rs1   = 4'($urandom_range(0, 3));
            rs2   = 4'($urandom_range(0, 3));
            rd    = 4'($urandom_range(0, 3));
            func  = 4'($urandom_range(0, 15));
            wb_en = 1'($urandom_range(0, 1));
            st_en = ($urandom_range(0, 2) == 0);
            addr  = 8'h40 + 8'($urandom_range(0, 15));
            tick();
        end
        drain();
        for (int a = 8'h40; a < 8'h50; a++) begin
            if (m_wr[a]) begin
                mem_raddr = 8'(a);
                tick();
                checks++;
                if (mem_rdata !== m_mem[a]) begin
                    errors++;
                    $display("FAIL rand_mem[%h]: got %h expected %h", a, mem_rdata, m_mem[a]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_forward();
        test_store();
        test_opcodes();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_alu_wb.md
Name: pipe_alu_wb

Overview:
- Parametrised single-clock 4-stage register-ALU-writeback-store pipeline.
- Generalises the fixed 16-bit, 16-register, 256-word datapath in data width, register-file depth and memory depth.
- Adds over the previous generation: async reset, valid/ready issue handshake, RAW hazard handling, a register preload port, a memory readback port, and fully defined ALU opcodes.
- Sits between the instruction source and the data memory; used as the team's standard ALU pipeline.

Parameters:
- DATA_W, 16, datapath, register and memory word width (>=4)
- REG_AW, 4, register-file address width (2**REG_AW registers)
- MEM_AW, 8, data-memory address width (2**MEM_AW words)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  pipeline accepts the instruction this cycle
- rs1  in  REG_AW  source register A
- rs2  in  REG_AW  source register B
- rd  in  REG_AW  destination register
- func  in  4  ALU opcode
- wb_en  in  1  write result to regbank[rd]
- st_en  in  1  store result to mem[addr]
- addr  in  MEM_AW  store address
- rf_we  in  1  preload write enable
- rf_waddr  in  REG_AW  preload address
- rf_wdata  in  DATA_W  preload data
- mem_raddr  in  MEM_AW  memory readback address
- mem_rdata  out  DATA_W  registered readback data
- zout  out  DATA_W  stage-3 result
- zout_valid  out  1  zout holds a valid instruction result

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, zout, zout_valid and mem_rdata go to 0. in_ready is forced to 0 while rst_n is low. Regbank and memory contents are not reset.
- Reset mid-operation: in-flight instructions are discarded. No regbank or memory write occurs from them after reset asserts.
- Issue: an instruction is accepted on a rising edge with in_valid && in_ready. Otherwise a bubble (valid=0) enters S1.
- S1 (accept edge t): latch A = regbank[rs1], B = regbank[rs2], plus rd, func, wb_en, st_en, addr.
- S2 (edge t+1): Z = ALU(A,B).
- S3 (edge t+2): Z moves to S3. zout = S3 Z and zout_valid = S3 valid at t+2. If wb_en, regbank[rd] <= Z on this same edge.
- S4 (edge t+3): if st_en, mem[addr] <= S3 Z.
- Latency: issue to zout is 2 edges, issue to memory write is 3 edges. Throughput is 1 per cycle when there is no hazard.
- Bubbles propagate without any write.
- Forwarding: when issuing, if rs1/rs2 equals the rd of a valid S2 instruction with wb_en, the operand takes S2 Z (the value being written to regbank this edge) instead of regbank.
- Stall: if rs1 or rs2 equals the rd of a valid S1 instruction with wb_en, in_ready = 0 for one cycle and a bubble enters S1. The issue then completes via S2 forwarding.
  - Both S1 and S2 matching: S1 wins (stall).
  - wb_en=0 instructions never cause a stall or a forward.
- ALU, all results truncated to DATA_W:
  - 0 A+B; 1 A-B; 2 low half of A*B; 3 A; 4 B
  - 5 A&B; 6 A|B; 7 A^B
  - 8 -A; 9 -B
  - 10 A>>1 logical; 11 A<<1
  - 12 (A<B unsigned) ? 1 : 0; 13 A>>>1 arithmetic; 14 ~A; 15 0
  - No X outputs.
- Preload: rf_we writes regbank[rf_waddr] <= rf_wdata. If the same address is written by pipeline writeback on the same edge, pipeline writeback wins. The preload is visible to an issue on the following edge, not the same edge.
- Readback: mem_rdata <= mem[mem_raddr] every edge. It is read-before-write: a same-edge store to the same address returns the old data, and the new data appears one cycle later.
- Address wrap: none needed; addresses are full-width indexes.

Test Plan:
- Reset then preload r1=0x0005, r2=0x0003; issue func0 rs1=1 rs2=2 rd=3 wb_en -> zout=0x0008 with zout_valid=1 two edges after issue; a later issue of func3 rs1=3 yields 0x0008.
- Back-to-back: issue func0 r1,r2->r4 then func1 r4,r2->r5 next cycle -> in_ready low exactly one cycle; r5=0x0005; zout sequence 0x0008, bubble, 0x0005.
- Forward from S2: issue r1+r2->r4, one idle cycle, then func2 r4*r2 -> no stall, zout=0x0018.
- Store/readback: func0 r1,r2 st_en addr=0x20 -> three edges later mem_raddr=0x20 returns 0x0008 on the next edge; a same-edge read returns the old value.
- Opcodes: A=0x8001, B=0x0002 -> func10 0x4000, func13 0xC000, func11 0x0002, func12 0, func14 0x7FFE, func15 0.
- Reset mid-flight: assert rst_n low one edge after issuing a wb_en+st_en instruction -> zout_valid=0, target register and memory word unchanged after reset release.
